// File: rtl/odo_sbox_small_inv.sv
// rtl/odo_sbox_small_inv.sv - runtime-loadable inverse of a 6-bit Odo small S-box
module odo_sbox_small_inv #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_data,
    output logic             busy,
    output logic             table_ok,
    output logic             table_err,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out
);

    localparam int DEPTH = 2 ** WIDTH;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_OK    = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] count;
    logic [DEPTH-1:0] seen;
    logic             dup;
    logic [WIDTH-1:0] inv_mem [DEPTH];

    logic xfer;
    logic last_beat;
    logic dup_now;
    logic lookup;

    // load_start outranks a coincident beat so a restart never consumes data
    assign ld_ready  = (state == ST_LOAD) && !load_start;
    assign xfer      = ld_valid && ld_ready;
    assign last_beat = (count == {WIDTH{1'b1}});
    assign dup_now   = seen[ld_data];
    assign lookup    = (state == ST_OK) && in_valid;

    assign busy      = (state == ST_LOAD);
    assign table_ok  = (state == ST_OK);
    assign table_err = (state == ST_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            count <= '0;
            seen  <= '0;
            dup   <= 1'b0;
        end else if (load_start) begin
            state <= ST_LOAD;
            count <= '0;
            seen  <= '0;
            dup   <= 1'b0;
        end else if (xfer) begin
            seen[ld_data] <= 1'b1;
            count         <= count + {{(WIDTH-1){1'b0}}, 1'b1};
            if (dup_now) begin
                dup <= 1'b1;
            end
            if (last_beat) begin
                state <= (dup || dup_now) ? ST_ERR : ST_OK;
            end
        end
    end

    // Table storage is deliberately unreset; the state machine gates its use.
    always_ff @(posedge clk) begin
        if (xfer) begin
            inv_mem[ld_data] <= count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= lookup;
            if (lookup) begin
                out <= inv_mem[in];
            end
        end
    end

endmodule

// File: tb/tb_odo_sbox_small_inv.sv
// tb/tb_odo_sbox_small_inv.sv - directed self-checking bench for odo_sbox_small_inv
module tb_odo_sbox_small_inv;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start;
    logic       ld_valid;
    logic       ld_ready;
    logic [5:0] ld_data;
    logic       busy;
    logic       table_ok;
    logic       table_err;
    logic       in_valid;
    logic [5:0] in;
    logic       out_valid;
    logic [5:0] out;

    int checks   = 0;
    int failures = 0;

    logic [5:0] sbox19 [64];
    logic [5:0] sbox19_inv [64];
    logic [5:0] tbl [64];

    always #5 clk = ~clk;

    odo_sbox_small_inv #(.WIDTH(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .busy       (busy),
        .table_ok   (table_ok),
        .table_err  (table_err),
        .in_valid   (in_valid),
        .in         (in),
        .out_valid  (out_valid),
        .out        (out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("ok_drop_after_start", table_ok, 1'b0);
        check("err_drop_after_start", table_err, 1'b0);
    endtask

    task automatic send_beats(input int first, input int last, input bit toggle);
        for (int i = first; i <= last; i++) begin
            if (toggle) begin
                ld_valid = 1'b0;
                step();
            end
            ld_valid = 1'b1;
            ld_data  = tbl[i];
            #1;
            check("busy_during_load", busy, 1'b1);
            check("ready_during_load", ld_ready, 1'b1);
            step();
        end
        ld_valid = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [5:0] v, input logic [5:0] exp);
        in_valid = 1'b1;
        in       = v;
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1'b1);
        check(tag, out, exp);
    endtask

    initial begin
        int b;
        logic [5:0] t;

        // Bijective stand-in for the small19 table, pinned at the entries the plan names.
        for (int x = 0; x < 64; x++) sbox19[x] = 6'((x * 37 + 11) & 63);
        for (int b2 = 0; b2 < 64; b2++) if (sbox19[b2] == 6'h35) b = b2;
        t = sbox19[0]; sbox19[0] = sbox19[b]; sbox19[b] = t;
        for (int b2 = 0; b2 < 64; b2++) if (sbox19[b2] == 6'h00) b = b2;
        t = sbox19[8]; sbox19[8] = sbox19[b]; sbox19[b] = t;
        for (int b2 = 0; b2 < 64; b2++) if (sbox19[b2] == 6'h11) b = b2;
        t = sbox19[63]; sbox19[63] = sbox19[b]; sbox19[b] = t;
        for (int x = 0; x < 64; x++) sbox19_inv[sbox19[x]] = 6'(x);

        rst_n = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        in_valid = 1'b0; in = '0;
        step(); step();
        #2 rst_n = 1'b1;
        step();

        check("rst_busy", busy, 1'b0);
        check("rst_ok", table_ok, 1'b0);
        check("rst_err", table_err, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 6'h00);
        check("rst_ready", ld_ready, 1'b0);

        // 1: lookups ignored while EMPTY
        in_valid = 1'b1; in = 6'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            check("empty_out_valid", out_valid, 1'b0);
            check("empty_ok", table_ok, 1'b0);
            check("empty_busy", busy, 1'b0);
        end
        in_valid = 1'b0;

        // 2: back-to-back load of the small19 table
        for (int i = 0; i < 64; i++) tbl[i] = sbox19[i];
        start_load();
        send_beats(0, 63, 1'b0);
        check("t2_ok", table_ok, 1'b1);
        check("t2_busy", busy, 1'b0);
        check("t2_err", table_err, 1'b0);
        in_valid = 1'b1; in = 6'h35;
        step();
        check("t2_lk35_valid", out_valid, 1'b1);
        check("t2_lk35", out, 6'h00);
        in = 6'h00;
        step();
        check("t2_lk00_valid", out_valid, 1'b1);
        check("t2_lk00", out, 6'h08);
        in = 6'h11;
        step();
        check("t2_lk11_valid", out_valid, 1'b1);
        check("t2_lk11", out, 6'h3f);
        in_valid = 1'b0;
        step();
        check("t2_idle_valid", out_valid, 1'b0);
        check("t2_idle_hold", out, 6'h3f);
        for (int v = 0; v < 64; v++) lookup("t2_sweep", 6'(v), sbox19_inv[v]);

        // 3: duplicate output value
        for (int i = 0; i < 64; i++) tbl[i] = 6'(i);
        tbl[5] = 6'h04;
        start_load();
        send_beats(0, 63, 1'b0);
        check("t3_err", table_err, 1'b1);
        check("t3_ok", table_ok, 1'b0);
        check("t3_busy", busy, 1'b0);
        in_valid = 1'b1; in = 6'h04;
        step();
        in_valid = 1'b0;
        check("t3_lookup_ignored", out_valid, 1'b0);

        // 4: stalled load restarted after beat 20, then a full fresh load
        for (int i = 0; i < 64; i++) tbl[i] = sbox19[i];
        start_load();
        send_beats(0, 20, 1'b1);
        step();
        load_start = 1'b1; ld_valid = 1'b1; ld_data = tbl[21];
        #1;
        check("t4_ready_on_restart", ld_ready, 1'b0);
        step();
        load_start = 1'b0; ld_valid = 1'b0;
        check("t4_busy_restart", busy, 1'b1);
        send_beats(0, 62, 1'b1);
        check("t4_not_done_early", busy, 1'b1);
        send_beats(63, 63, 1'b1);
        check("t4_ok", table_ok, 1'b1);
        lookup("t4_lk35", 6'h35, 6'h00);
        lookup("t4_lk00", 6'h00, 6'h08);
        lookup("t4_lk11", 6'h11, 6'h3f);
        for (int v = 0; v < 64; v += 7) lookup("t4_sample", 6'(v), sbox19_inv[v]);

        // 5: load_start coincident with a lookup uses the old table
        load_start = 1'b1; in_valid = 1'b1; in = 6'h35;
        step();
        load_start = 1'b0; in_valid = 1'b0;
        check("t5_out_valid", out_valid, 1'b1);
        check("t5_out", out, 6'h00);
        check("t5_ok", table_ok, 1'b0);
        check("t5_busy", busy, 1'b1);

        // 6: asynchronous reset mid-load
        send_beats(0, 30, 1'b0);
        ld_valid = 1'b1; ld_data = tbl[31];
        #3 rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_ok", table_ok, 1'b0);
        check("t6_err", table_err, 1'b0);
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_ready", ld_ready, 1'b0);
        step();
        #2 rst_n = 1'b1;
        in_valid = 1'b1; in = 6'h35;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_stay_empty_busy", busy, 1'b0);
            check("t6_stay_empty_ok", table_ok, 1'b0);
            check("t6_stay_empty_lookup", out_valid, 1'b0);
        end
        in_valid = 1'b0; ld_valid = 1'b0;
        start_load();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/odo_sbox_small_inv.md
Name: odo_sbox_small_inv

Overview:
Runtime-loadable inverse of a 6-bit Odo small S-box, used on the verification/decrypt path. The block:
- Accepts the 64-entry forward table as a stream in address order.
- Builds the inverse table and checks that the forward table is a bijection.
- Serves registered inverse lookups with one-cycle latency once a valid table is held.
- Is reloaded whenever the Odo key epoch changes (e.g. with the odo_sbox_small19 contents).

Parameters:
- WIDTH, 6: S-box word width. Table depth is 2**WIDTH. Only 6 is verified.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  one-cycle pulse; begins or restarts a table load.
- ld_valid  input  1  a forward-table beat is present on ld_data.
- ld_ready  output  1  block accepts a beat this cycle.
- ld_data  input  WIDTH  forward entry for the implicit address held in the load counter.
- busy  output  1  a load is in progress.
- table_ok  output  1  valid bijective inverse table is held.
- table_err  output  1  the last load contained a duplicate output value.
- in_valid  input  1  lookup request.
- in  input  WIDTH  value to invert.
- out_valid  output  1  out holds a lookup result.
- out  output  WIDTH  inverse result, i.e. out = x where fwd[x] = in.

Behaviour:
- Reset (rst_n low, async):
  - State = EMPTY; load counter = 0; seen bitmap (2**WIDTH bits) = 0.
  - busy = 0, table_ok = 0, table_err = 0, out_valid = 0, out = 0.
  - Inverse table contents are not reset.
- States and transitions:
  - EMPTY, OK, ERR: load_start moves to LOAD.
  - LOAD: load_start restarts the load.
  - LOAD → OK: after beat 63 with no duplicate seen.
  - LOAD → ERR: after beat 63 with a duplicate seen.
- Outputs by state:
  - busy = 1 only in LOAD.
  - table_ok = 1 only in OK.
  - table_err = 1 only in ERR.
- Load start:
  - load_start in any state clears the counter, seen bitmap and dup flag on that edge.
  - table_ok and table_err drop to 0 in the cycle after load_start.
- Load handshake:
  - ld_ready = (state == LOAD) && !load_start (combinational).
  - A beat transfers when ld_valid && ld_ready.
  - On a transfer: inv[ld_data] <= counter; seen[ld_data] <= 1; counter increments.
  - If seen[ld_data] was already 1, the sticky dup flag is set. The write still happens (last writer wins).
  - Beats with ld_valid low stall the load with no timeout.
- Counter:
  - WIDTH bits.
  - The transfer with counter = 2**WIDTH-1 is the last. The counter wraps to 0 and the state leaves LOAD on that same edge.
  - Bitmap and counter are not cleared on completion.
- load_start coincident with ld_valid: load_start wins and the beat is not consumed (ld_ready = 0).
- Lookup:
  - Accepted only when state == OK and in_valid = 1.
  - Next edge: out <= inv[in]; out_valid <= 1.
  - A cycle with no accepted lookup gives out_valid <= 0. out holds its last value.
  - Latency is exactly 1 cycle, with full throughput of one lookup per cycle.
- Lookup in a non-OK state (EMPTY, LOAD, ERR): ignored, out_valid = 0.
- load_start coincident with an accepted lookup in OK: the lookup completes from the old table contents.
- Reset mid-load: returns to EMPTY; the partial table is unusable until a complete reload.
- Only one of table_ok, table_err, busy is ever high.

Test Plan:
1. Reset, then in_valid=1 with in=0x00 for 4 cycles → out_valid stays 0; table_ok=0, busy=0.
2. load_start, then stream the odo_sbox_small19 table (addr 0=0x35, 8=0x00, 63=0x11) back-to-back → busy for 64 cycles; table_ok=1 on the cycle after beat 63. Lookups 0x35→0x00, 0x00→0x08, 0x11→0x3f on consecutive cycles → out_valid=1 on each following cycle with those values.
3. Load identity except entry 5 = 0x04 (0x04 appears twice) → after beat 63 table_err=1, table_ok=0. Lookup of 0x04 → no out_valid.
4. Load with ld_valid toggled every other cycle, plus load_start asserted after beat 20 together with ld_valid → that beat is not accepted and the counter restarts. A full fresh 64-beat load then yields table_ok=1 and correct inverses.
5. In OK, assert load_start together with in_valid, in=0x35 → out=0x00, out_valid=1 next cycle. In the same cycle table_ok=0 and busy=1.
6. Deassert rst_n asynchronously mid-load (between edges, after beat 30) → busy, table_ok, table_err, out_valid all 0 immediately. The state stays EMPTY until the next load_start.
